// File: rtl/mcu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_pkg
//  Description : Shared constants for the multi-cycle MIPS control unit:
//                opcode/funct codes, ALUOp codes, datapath mux selects and
//                the FSM state enumeration (encodings are externally visible
//                through state_dbg and must not change).
//  Revision    : 1.0  initial release
// ============================================================================
package mcu_pkg;

    // Instruction opcodes (IR[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    // funct field (IR[5:0]) of an R-type jr
    localparam logic [5:0] c_FUNCT_JR = 6'b001000;

    // ALUOp codes
    localparam logic [2:0] c_ALU_ADD   = 3'b000;
    localparam logic [2:0] c_ALU_SUB   = 3'b001;
    localparam logic [2:0] c_ALU_FUNCT = 3'b010;
    localparam logic [2:0] c_ALU_AND   = 3'b100;
    localparam logic [2:0] c_ALU_ADDI  = 3'b101;

    // ALUSrcB selects
    localparam logic [1:0] c_SRCB_RT    = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR  = 2'b01;
    localparam logic [1:0] c_SRCB_IMM   = 2'b10;
    localparam logic [1:0] c_SRCB_IMMSH = 2'b11;

    // PCSource selects
    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] c_PCSRC_RS     = 2'b11;

    // MemToReg selects
    localparam logic [1:0] c_M2R_ALUOUT = 2'b00;
    localparam logic [1:0] c_M2R_MDR    = 2'b01;
    localparam logic [1:0] c_M2R_PC     = 2'b10;

    // RegDst selects
    localparam logic [1:0] c_DST_RT = 2'b00;
    localparam logic [1:0] c_DST_RD = 2'b01;
    localparam logic [1:0] c_DST_RA = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB_I     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WB   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_JAL      = 4'd13,
        S_JR       = 4'd14,
        S_HALT     = 4'd15
    } state_t;

    // States that stall on the memory handshake and are watchdog-guarded
    function automatic logic isWaitState(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcu_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_wait_timer
//  Description : Watchdog counter for memory waits. Counts stalled cycles;
//                expired flags that the current stalled cycle is the
//                MAX_WAIT-th one, so a missing mem_ready now is a timeout.
//  Ports       : clk, rst (async, active-high)
//                clear   - zero the count (state change)
//                enable  - count one more stalled cycle
//                expired - count has reached MAX_WAIT-1
//  Revision    : 1.0  initial release
// ============================================================================
module mcu_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] r_count;

    assign expired = (r_count == CNT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_unit
//  Description : Moore FSM control unit for the multi-cycle MIPS datapath.
//                Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, stalls on
//                mem_ready and traps memory waits longer than MAX_WAIT into
//                an absorbing HALT with a sticky bus_error.
//  Build macro : ILLEGAL_TRAP_EN - adds illegal_op output; undefined opcodes
//                halt instead of executing as nop.
//  Ports       : clk, rst (async, active-high); opcode, funct, mem_ready in;
//                datapath strobes/selects, bus_error, state_dbg out.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int OP_W     = 6,
    parameter int FUNCT_W  = 6,
    parameter int ALUOP_W  = 3,
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [OP_W-1:0]    opcode,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         MemToReg,
    output logic [1:0]         RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSource,
    output logic               bus_error,
    output logic [3:0]         state_dbg
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic               illegal_op
`endif
);

    state_t     r_state;
    state_t     w_nextState;
    logic       r_busError;
    logic       w_setBusErr;
    logic       w_expired;
    logic       w_waitState;
    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [2:0] w_aluOp;

    assign w_op        = 6'(opcode);
    assign w_funct     = 6'(funct);
    assign w_waitState = isWaitState(r_state);

    // Any state change restarts the watchdog, so each wait is timed alone.
    mcu_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_waitTimer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_nextState != r_state),
        .enable  (w_waitState && !mem_ready),
        .expired (w_expired)
    );

`ifdef ILLEGAL_TRAP_EN
    logic r_illegalOp;
    logic w_setIllegal;
    assign illegal_op = r_illegalOp;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busError <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            r_illegalOp <= 1'b0;
`endif
        end else begin
            r_state <= w_nextState;
            if (w_setBusErr) r_busError <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
            if (w_setIllegal) r_illegalOp <= 1'b1;
`endif
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_setBusErr = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        w_setIllegal = 1'b0;
`endif
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = c_M2R_ALUOUT;
        RegDst      = c_DST_RT;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = c_SRCB_RT;
        w_aluOp     = c_ALU_ADD;
        PCSource    = c_PCSRC_ALU;

        case (r_state)
            S_IDLE: w_nextState = S_FETCH;

            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = c_SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) begin
                    w_nextState = S_DECODE;
                end else if (w_expired) begin
                    w_nextState = S_HALT;
                    w_setBusErr = 1'b1;
                end
            end

            S_DECODE: begin
                // Speculative branch target: PC + (imm << 2)
                ALUSrcB = c_SRCB_IMMSH;
                case (w_op)
                    c_OP_RTYPE: w_nextState = (w_funct == c_FUNCT_JR) ? S_JR : S_EXEC_R;
                    c_OP_ADDI,
                    c_OP_ANDI:  w_nextState = S_EXEC_I;
                    c_OP_LW,
                    c_OP_SW:    w_nextState = S_MEM_ADDR;
                    c_OP_BEQ:   w_nextState = S_BRANCH;
                    c_OP_J:     w_nextState = S_JUMP;
                    c_OP_JAL:   w_nextState = S_JAL;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        w_nextState  = S_HALT;
                        w_setIllegal = 1'b1;
`else
                        w_nextState  = S_FETCH;
`endif
                    end
                endcase
            end

            S_EXEC_R: begin
                ALUSrcA     = 1'b1;
                w_aluOp     = c_ALU_FUNCT;
                w_nextState = S_WB_R;
            end

            S_WB_R: begin
                RegDst      = c_DST_RD;
                RegWrite    = 1'b1;
                w_nextState = S_FETCH;
            end

            S_EXEC_I: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = c_SRCB_IMM;
                w_aluOp     = (w_op == c_OP_ANDI) ? c_ALU_AND : c_ALU_ADDI;
                w_nextState = S_WB_I;
            end

            S_WB_I: begin
                RegWrite    = 1'b1;
                w_nextState = S_FETCH;
            end

            S_MEM_ADDR: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = c_SRCB_IMM;
                w_nextState = (w_op == c_OP_SW) ? S_MEM_WR : S_MEM_RD;
            end

            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    w_nextState = S_MEM_WB;
                end else if (w_expired) begin
                    w_nextState = S_HALT;
                    w_setBusErr = 1'b1;
                end
            end

            S_MEM_WB: begin
                MemToReg    = c_M2R_MDR;
                RegWrite    = 1'b1;
                w_nextState = S_FETCH;
            end

            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    w_nextState = S_FETCH;
                end else if (w_expired) begin
                    w_nextState = S_HALT;
                    w_setBusErr = 1'b1;
                end
            end

            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                w_aluOp     = c_ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = c_PCSRC_ALUOUT;
                w_nextState = S_FETCH;
            end

            S_JUMP: begin
                PCWrite     = 1'b1;
                PCSource    = c_PCSRC_JUMP;
                w_nextState = S_FETCH;
            end

            S_JAL: begin
                PCWrite     = 1'b1;
                PCSource    = c_PCSRC_JUMP;
                RegDst      = c_DST_RA;
                MemToReg    = c_M2R_PC;
                RegWrite    = 1'b1;
                w_nextState = S_FETCH;
            end

            S_JR: begin
                PCWrite     = 1'b1;
                PCSource    = c_PCSRC_RS;
                w_nextState = S_FETCH;
            end

            S_HALT: w_nextState = S_HALT;

            default: w_nextState = S_HALT;
        endcase
    end

    assign ALUOp     = ALUOP_W'(w_aluOp);
    assign bus_error = r_busError;
    assign state_dbg = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control_unit
//  Description : Self-checking bench for multicycle_control_unit. Each
//                instruction is expanded into the list of steps it should
//                take (with its memory stall pattern) and every cycle the
//                state and all strobes are compared against the step table.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_control_unit;

    localparam int MAX_WAIT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0] MemToReg, RegDst;
    logic       RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic [1:0] PCSource;
    logic       bus_error;
    logic [3:0] state_dbg;

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    multicycle_control_unit #(
        .OP_W(6), .FUNCT_W(6), .ALUOP_W(3), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .bus_error(bus_error), .state_dbg(state_dbg)
    );

    logic [18:0] obsOut;
    assign obsOut = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    typedef struct {
        int   st;
        logic mr;
    } step_t;

    // Control word each step must present, straight from the step table.
    function automatic logic [18:0] expOut(input int st, input logic [5:0] op, input logic mr);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, rw = 0, srca = 0;
        logic [1:0] m2r = 0, rdst = 0, srcb = 0, pcs = 0;
        logic [2:0] aluop = 0;
        case (st)
            1:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            2:  srcb = 2'b11;
            3:  begin srca = 1; aluop = 3'b010; end
            4:  begin rdst = 2'b01; rw = 1; end
            5:  begin srca = 1; srcb = 2'b10; aluop = (op == 6'b001100) ? 3'b100 : 3'b101; end
            6:  rw = 1;
            7:  begin srca = 1; srcb = 2'b10; end
            8:  begin mrd = 1; iord = 1; end
            9:  begin m2r = 2'b01; rw = 1; end
            10: begin mwr = 1; iord = 1; end
            11: begin srca = 1; aluop = 3'b001; pcwc = 1; pcs = 2'b01; end
            12: begin pcw = 1; pcs = 2'b10; end
            13: begin pcw = 1; pcs = 2'b10; rdst = 2'b10; m2r = 2'b10; rw = 1; end
            14: begin pcw = 1; pcs = 2'b11; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop, pcs};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Runs one instruction starting in FETCH; wf/wm = stalled cycles in
    // the fetch and in the data-memory access.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int wf, input int wm);
        step_t plan[$];
        for (int i = 0; i < wf; i++) plan.push_back('{1, 1'b0});
        plan.push_back('{1, 1'b1});
        plan.push_back('{2, rbit()});
        case (op)
            6'b000000: begin
                if (fn == 6'b001000) plan.push_back('{14, rbit()});
                else begin
                    plan.push_back('{3, rbit()});
                    plan.push_back('{4, rbit()});
                end
            end
            6'b001000, 6'b001100: begin
                plan.push_back('{5, rbit()});
                plan.push_back('{6, rbit()});
            end
            6'b100011: begin
                plan.push_back('{7, rbit()});
                for (int i = 0; i < wm; i++) plan.push_back('{8, 1'b0});
                plan.push_back('{8, 1'b1});
                plan.push_back('{9, rbit()});
            end
            6'b101011: begin
                plan.push_back('{7, rbit()});
                for (int i = 0; i < wm; i++) plan.push_back('{10, 1'b0});
                plan.push_back('{10, 1'b1});
            end
            6'b000100: plan.push_back('{11, rbit()});
            6'b000010: plan.push_back('{12, rbit()});
            6'b000011: plan.push_back('{13, rbit()});
            default: ;
        endcase
        foreach (plan[k]) begin
            opcode    = op;
            funct     = fn;
            mem_ready = plan[k].mr;
            #1;
            chk("state", 32'(state_dbg), 32'(plan[k].st));
            chk("outputs", 32'(obsOut), 32'(expOut(plan[k].st, op, plan[k].mr)));
            chk("bus_error", 32'(bus_error), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [5:0] ops [9];
        logic [5:0] op, fn;
        ops = '{6'h00, 6'h08, 6'h0C, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h3F};

        rst = 1'b1; mem_ready = 1'b0; opcode = '0; funct = '0;
        #12;
        chk("reset_state", 32'(state_dbg), 32'd0);
        chk("reset_outputs", 32'(obsOut), 32'd0);
        chk("reset_bus_error", 32'(bus_error), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Directed instructions
        run_instr(6'h00, 6'b100000, 0, 0);   // add
        run_instr(6'h23, 6'h00, 0, 3);       // lw, 3 stall cycles
        run_instr(6'h04, 6'h00, 0, 0);       // beq
        run_instr(6'h03, 6'h00, 0, 0);       // jal
        run_instr(6'h00, 6'b001000, 0, 0);   // jr
        run_instr(6'h2B, 6'h00, 1, 2);       // sw
        run_instr(6'h08, 6'h11, 0, 0);       // addi
        run_instr(6'h0C, 6'h22, 2, 0);       // andi
        run_instr(6'h02, 6'h00, 0, 0);       // j
        run_instr(6'h3F, 6'h00, 0, 0);       // undefined -> nop
        // Long waits in successive states must not accumulate
        run_instr(6'h23, 6'h00, MAX_WAIT - 3, MAX_WAIT - 3);
        run_instr(6'h2B, 6'h00, MAX_WAIT - 1, MAX_WAIT - 1);

        // Random instruction stream
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 8)];
            fn = 6'($urandom);
            if (op == 6'h00 && $urandom_range(0, 2) == 0) fn = 6'b001000;
            run_instr(op, fn, $urandom_range(0, 4), $urandom_range(0, 4));
        end

        // Asynchronous reset in the middle of a stalled load
        opcode = 6'h23; mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_lw_state", 32'(state_dbg), 32'd8);
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(state_dbg), 32'd0);
        chk("async_rst_outputs", 32'(obsOut), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_fetch", 32'(state_dbg), 32'd1);

        // Fetch timeout: MAX_WAIT stalled cycles then HALT + bus_error
        mem_ready = 1'b0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            chk("wd_wait_state", 32'(state_dbg), 32'd1);
            chk("wd_wait_err", 32'(bus_error), 32'd0);
            @(posedge clk); #1;
        end
        chk("wd_halt_state", 32'(state_dbg), 32'd15);
        chk("wd_bus_error", 32'(bus_error), 32'd1);
        chk("wd_halt_outputs", 32'(obsOut), 32'd0);
        mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("halt_sticky_state", 32'(state_dbg), 32'd15);
            chk("halt_sticky_err", 32'(bus_error), 32'd1);
        end
        rst = 1'b1;
        #1;
        chk("err_cleared", 32'(bus_error), 32'd0);
        chk("err_rst_state", 32'(state_dbg), 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // mem_ready on the last permitted cycle wins over the timeout
        mem_ready = 1'b0;
        for (int i = 0; i < MAX_WAIT - 1; i++) begin
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        #1;
        chk("edge_irwrite", 32'(IRWrite), 32'd1);
        chk("edge_state", 32'(state_dbg), 32'd1);
        @(posedge clk); #1;
        chk("edge_decode", 32'(state_dbg), 32'd2);
        chk("edge_no_err", 32'(bus_error), 32'd0);
        opcode = 6'h3F;
        @(posedge clk); #1;
        chk("edge_back_fetch", 32'(state_dbg), 32'd1);
        run_instr(6'h00, 6'b100010, 0, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
`default_nettype wire
